// File: rtl/down_counter_tff.sv
// Synchronous down counter built from per-bit toggle flip-flops, with reload at zero
// (or saturation), clamped parallel load, terminal count, borrow pulse and elapsed count.
module down_counter_tff #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_count;
  logic             r_borrow;

  logic [WIDTH-1:0] w_low_zero;
  logic [WIDTH-1:0] w_tog_en;
  logic [WIDTH-1:0] w_q_tff;
  logic [WIDTH-1:0] w_d_clamp;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_zero;
  logic             w_borrow_nxt;

  // Bit i toggles when counting and every lower bit is already 0 (a borrow ripples up).
  assign w_low_zero[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_low_zero
    assign w_low_zero[i] = w_low_zero[i-1] & ~r_q[i-1];
  end

  assign w_tog_en  = {WIDTH{t}} & w_low_zero;
  assign w_q_tff   = r_q ^ w_tog_en;
  assign w_zero    = (r_q == '0);
  assign w_d_clamp = clamp_load(d);

  always_comb begin
    w_q_nxt      = r_q;
    w_count_nxt  = r_count;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_q_nxt     = w_d_clamp;
      w_count_nxt = MAX_V - w_d_clamp;
    end else if (t) begin
      if (w_zero) begin
        // At zero the raw toggles would give all-ones, so the reload overrides them.
        if (!SATURATE) begin
          w_q_nxt      = MAX_V;
          w_count_nxt  = '0;
          w_borrow_nxt = 1'b1;
        end
      end else begin
        w_q_nxt     = w_q_tff;
        w_count_nxt = r_count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= MAX_V;
      r_count  <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_count  <= w_count_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign q      = r_q;
  assign count  = r_count;
  assign tc     = w_zero;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_down_counter_tff.sv
// Drives three counter builds (wrap MAX=15, wrap MAX=10, saturate MAX=15) with shared
// stimulus and compares every output each cycle against a behavioural model.
module tb_down_counter_tff;

  logic       clk;
  logic       rst;
  logic       t;
  logic       load;
  logic [3:0] d;

  logic [3:0] q_a, count_a, q_b, count_b, q_c, count_c;
  logic       tc_a, borrow_a, tc_b, borrow_b, tc_c, borrow_c;

  int n_checks = 0;
  int n_errors = 0;

  localparam int MAXS [3] = '{15, 10, 15};
  localparam int SATS [3] = '{0, 0, 1};
  int mq [3];
  int mb [3];

  down_counter_tff #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u_wrap15 (
    .clk(clk), .rst(rst), .t(t), .load(load), .d(d),
    .q(q_a), .count(count_a), .tc(tc_a), .borrow(borrow_a)
  );

  down_counter_tff #(.WIDTH(4), .MAX(10), .SATURATE(1'b0)) u_wrap10 (
    .clk(clk), .rst(rst), .t(t), .load(load), .d(d),
    .q(q_b), .count(count_b), .tc(tc_b), .borrow(borrow_b)
  );

  down_counter_tff #(.WIDTH(4), .MAX(15), .SATURATE(1'b1)) u_sat15 (
    .clk(clk), .rst(rst), .t(t), .load(load), .d(d),
    .q(q_c), .count(count_c), .tc(tc_c), .borrow(borrow_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: the counter's value and borrow flag as plain integers.
  task automatic model_edge(input logic r, input logic tt, input logic ld, input int dd);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mq[k] = MAXS[k];
        mb[k] = 0;
      end else if (ld) begin
        mq[k] = (dd > MAXS[k]) ? MAXS[k] : dd;
        mb[k] = 0;
      end else if (tt) begin
        if (mq[k] > 0) begin
          mq[k] = mq[k] - 1;
          mb[k] = 0;
        end else if (SATS[k] != 0) begin
          mb[k] = 0;
        end else begin
          mq[k] = MAXS[k];
          mb[k] = 1;
        end
      end else begin
        mb[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    check("wrap15.q",      int'(q_a),      mq[0]);
    check("wrap15.count",  int'(count_a),  MAXS[0] - mq[0]);
    check("wrap15.tc",     int'(tc_a),     int'(mq[0] == 0));
    check("wrap15.borrow", int'(borrow_a), mb[0]);
    check("wrap10.q",      int'(q_b),      mq[1]);
    check("wrap10.count",  int'(count_b),  MAXS[1] - mq[1]);
    check("wrap10.tc",     int'(tc_b),     int'(mq[1] == 0));
    check("wrap10.borrow", int'(borrow_b), mb[1]);
    check("sat15.q",       int'(q_c),      mq[2]);
    check("sat15.count",   int'(count_c),  MAXS[2] - mq[2]);
    check("sat15.tc",      int'(tc_c),     int'(mq[2] == 0));
    check("sat15.borrow",  int'(borrow_c), mb[2]);
  endtask

  task automatic step(input logic r, input logic tt, input logic ld, input logic [3:0] dd);
    rst  = r;
    t    = tt;
    load = ld;
    d    = dd;
    @(posedge clk);
    model_edge(r, tt, ld, int'(dd));
    #1;
    check_all();
  endtask

  initial begin
    rst  = 1'b1;
    t    = 1'b1;
    load = 1'b0;
    d    = 4'd0;

    // Reset held with t=1: value must stay at MAX.
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Free count through a wrap; the saturating build sticks at 0.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 4'd0);

    // Enable gap from MAX.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 34; i++) step(1'b0, (i % 2) == 0, 1'b0, 4'd0);

    // Load with t=1 (no decrement), then an over-range load (clamps on the MAX=10 build).
    step(1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd13);
    step(1'b0, 1'b0, 1'b0, 4'd0);

    // Load at q==0 with t=1 must not wrap or raise borrow.
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // Reset on what would be the wrap edge.
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // Wrap then reset while borrow is high.
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd9);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 47) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
